// File: rtl/clint_timer_pkg.sv
// Shared constants, state encodings and byte-merge helper for the CLINT timer block.
package clint_params;

  localparam int XLEN   = 64;
  localparam int ALEN   = 32;
  localparam int STRB_W = XLEN / 8;

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_RESP} r_state_e;
  typedef enum logic [1:0] {REG_NONE, REG_MSIP, REG_MTIMECMP, REG_MTIME} reg_sel_e;

  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]   old_v,
                                                  input logic [XLEN-1:0]   new_v,
                                                  input logic [STRB_W-1:0] strb);
    logic [XLEN-1:0] r;
    r = old_v;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_timer_prescaler.sv
// Divides clk by TICK_DIV, emitting a one-cycle tick on the terminal count.
module clint_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_timer.sv
// RISC-V machine timer / software-interrupt registers behind an AXI4-Lite responder.
module clint_timer
  import clint_params::*;
#(
  parameter int TICK_DIV  = 1,
  parameter int ADDR_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_bus_awvalid_i,
  output logic              data_bus_awready_o,
  input  logic [ALEN-1:0]   data_bus_awaddr_i,
  input  logic              data_bus_wvalid_i,
  output logic              data_bus_wready_o,
  input  logic [XLEN-1:0]   data_bus_wdata_i,
  input  logic [STRB_W-1:0] data_bus_wstrb_i,
  output logic              data_bus_bvalid_o,
  input  logic              data_bus_bready_i,
  output logic [1:0]        data_bus_bresp_o,
  input  logic              data_bus_arvalid_i,
  output logic              data_bus_arready_o,
  input  logic [ALEN-1:0]   data_bus_araddr_i,
  output logic              data_bus_rvalid_o,
  input  logic              data_bus_rready_i,
  output logic [XLEN-1:0]   data_bus_rdata_o,
  output logic [1:0]        data_bus_rresp_o,
  output logic              timer_irq_o,
  output logic              soft_irq_o
);

  function automatic reg_sel_e decode(input logic [ADDR_BITS-1:0] off);
    logic [ADDR_BITS-1:0] a;
    a = off & ~ADDR_BITS'(7);
    if (a == ADDR_BITS'(OFF_MSIP))     return REG_MSIP;
    if (a == ADDR_BITS'(OFF_MTIMECMP)) return REG_MTIMECMP;
    if (a == ADDR_BITS'(OFF_MTIME))    return REG_MTIME;
    return REG_NONE;
  endfunction

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [ADDR_BITS-1:0] awaddr_q;
  logic [XLEN-1:0]      wdata_q;
  logic [STRB_W-1:0]    wstrb_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [XLEN-1:0]      rdata_q;
  logic                 msip_q, msip_d;
  logic [63:0]          mtimecmp_q, mtimecmp_d;
  logic [63:0]          mtime_q, mtime_d, mtime_base;
  logic                 timer_irq_q, soft_irq_q;

  logic                 aw_hs, w_hs, ar_hs, do_write, tick, restart;
  logic [ADDR_BITS-1:0] wr_off;
  logic [XLEN-1:0]      wr_data;
  logic [STRB_W-1:0]    wr_strb;
  reg_sel_e             wr_sel, rd_sel;
  logic [XLEN-1:0]      rd_val;
  logic [1:0]           rd_resp;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^{data_bus_awaddr_i[ALEN-1:ADDR_BITS], data_bus_araddr_i[ALEN-1:ADDR_BITS]};

  always_comb begin
    data_bus_awready_o = 1'b0;
    data_bus_wready_o  = 1'b0;
    data_bus_bvalid_o  = 1'b0;
    unique case (w_state_q)
      W_IDLE:    begin data_bus_awready_o = 1'b1; data_bus_wready_o = 1'b1; end
      W_HAVE_AW: data_bus_wready_o  = 1'b1;
      W_HAVE_W:  data_bus_awready_o = 1'b1;
      W_RESP:    data_bus_bvalid_o  = 1'b1;
      default:   ;
    endcase
    data_bus_arready_o = (r_state_q == R_IDLE);
    data_bus_rvalid_o  = (r_state_q == R_RESP);
  end

  assign aw_hs = data_bus_awvalid_i & data_bus_awready_o;
  assign w_hs  = data_bus_wvalid_i  & data_bus_wready_o;
  assign ar_hs = data_bus_arvalid_i & data_bus_arready_o;

  // Same-cycle handshakes take the bus values; otherwise the half latched earlier.
  assign wr_off  = aw_hs ? data_bus_awaddr_i[ADDR_BITS-1:0] : awaddr_q;
  assign wr_data = w_hs  ? data_bus_wdata_i : wdata_q;
  assign wr_strb = w_hs  ? data_bus_wstrb_i : wstrb_q;
  assign wr_sel  = decode(wr_off);

  always_comb begin
    w_state_d = w_state_q;
    do_write  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          do_write  = 1'b1;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          w_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs)  begin do_write = 1'b1; w_state_d = W_RESP; end
      W_HAVE_W:  if (aw_hs) begin do_write = 1'b1; w_state_d = W_RESP; end
      W_RESP:    if (data_bus_bready_i) w_state_d = W_IDLE;
      default:   w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      R_RESP:  if (data_bus_rready_i) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // A software mtime write overlays the (possibly incremented) value byte by byte.
  always_comb begin
    mtime_base = tick ? mtime_q + 64'd1 : mtime_q;
    mtime_d    = mtime_base;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    restart    = 1'b0;
    if (do_write) begin
      unique case (wr_sel)
        REG_MSIP:     if (wr_strb[0]) msip_d = wr_data[0];
        REG_MTIMECMP: mtimecmp_d = merge_bytes(mtimecmp_q, wr_data, wr_strb);
        REG_MTIME: begin
          mtime_d = merge_bytes(mtime_base, wr_data, wr_strb);
          restart = |wr_strb;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_sel  = decode(data_bus_araddr_i[ADDR_BITS-1:0]);
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    unique case (rd_sel)
      REG_MSIP:     rd_val = {{(XLEN-1){1'b0}}, msip_q};
      REG_MTIMECMP: rd_val = mtimecmp_q;
      REG_MTIME:    rd_val = mtime_q;
      default:      rd_resp = RESP_DECERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      msip_q      <= 1'b0;
      mtimecmp_q  <= '1;
      mtime_q     <= '0;
      timer_irq_q <= 1'b0;
      soft_irq_q  <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      msip_q      <= msip_d;
      mtimecmp_q  <= mtimecmp_d;
      mtime_q     <= mtime_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
      soft_irq_q  <= msip_q;
      if (do_write) bresp_q <= (wr_sel == REG_NONE) ? RESP_DECERR : RESP_OKAY;
      if (ar_hs)    rresp_q <= rd_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_q <= data_bus_awaddr_i[ADDR_BITS-1:0];
    if (w_hs) begin
      wdata_q <= data_bus_wdata_i;
      wstrb_q <= data_bus_wstrb_i;
    end
    if (ar_hs) rdata_q <= rd_val;
  end

  assign data_bus_bresp_o = bresp_q;
  assign data_bus_rresp_o = rresp_q;
  assign data_bus_rdata_o = rdata_q;
  assign timer_irq_o      = timer_irq_q;
  assign soft_irq_o       = soft_irq_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench: two instances (TICK_DIV 4 and 1) share one AXI4-Lite master.
module tb_clint_timer;
  import clint_params::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              awvalid, wvalid, bready, arvalid, rready;
  logic [ALEN-1:0]   awaddr, araddr;
  logic [XLEN-1:0]   wdata;
  logic [STRB_W-1:0] wstrb;

  logic            a_awready, a_wready, a_bvalid, a_arready, a_rvalid, a_tirq, a_sirq;
  logic [1:0]      a_bresp, a_rresp;
  logic [XLEN-1:0] a_rdata;
  logic            b_awready, b_wready, b_bvalid, b_arready, b_rvalid, b_tirq, b_sirq;
  logic [1:0]      b_bresp, b_rresp;
  logic [XLEN-1:0] b_rdata;

  int passes = 0;
  int total  = 0;

  clint_timer #(.TICK_DIV(4), .ADDR_BITS(16)) u_div4 (
    .clk(clk), .rst(rst),
    .data_bus_awvalid_i(awvalid), .data_bus_awready_o(a_awready), .data_bus_awaddr_i(awaddr),
    .data_bus_wvalid_i(wvalid), .data_bus_wready_o(a_wready), .data_bus_wdata_i(wdata),
    .data_bus_wstrb_i(wstrb), .data_bus_bvalid_o(a_bvalid), .data_bus_bready_i(bready),
    .data_bus_bresp_o(a_bresp), .data_bus_arvalid_i(arvalid), .data_bus_arready_o(a_arready),
    .data_bus_araddr_i(araddr), .data_bus_rvalid_o(a_rvalid), .data_bus_rready_i(rready),
    .data_bus_rdata_o(a_rdata), .data_bus_rresp_o(a_rresp),
    .timer_irq_o(a_tirq), .soft_irq_o(a_sirq)
  );

  clint_timer #(.TICK_DIV(1), .ADDR_BITS(16)) u_div1 (
    .clk(clk), .rst(rst),
    .data_bus_awvalid_i(awvalid), .data_bus_awready_o(b_awready), .data_bus_awaddr_i(awaddr),
    .data_bus_wvalid_i(wvalid), .data_bus_wready_o(b_wready), .data_bus_wdata_i(wdata),
    .data_bus_wstrb_i(wstrb), .data_bus_bvalid_o(b_bvalid), .data_bus_bready_i(bready),
    .data_bus_bresp_o(b_bresp), .data_bus_arvalid_i(arvalid), .data_bus_arready_o(b_arready),
    .data_bus_araddr_i(araddr), .data_bus_rvalid_o(b_rvalid), .data_bus_rready_i(rready),
    .data_bus_rdata_o(b_rdata), .data_bus_rresp_o(b_rresp),
    .timer_irq_o(b_tirq), .soft_irq_o(b_sirq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Tasks start and end just after a falling edge; both halves issued together.
  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input logic [1:0] exp_resp);
    awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; wstrb = strb;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, " bvalid"}, a_bvalid, 1);
    check({tag, " bresp"}, a_bresp, exp_resp);
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [63:0] d4,
                          output logic [63:0] d1, output logic [1:0] resp);
    arvalid = 1'b1; araddr = addr;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid one cycle after AR", a_rvalid, 1);
    d4 = a_rdata; d1 = b_rdata; resp = a_rresp;
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    logic [63:0] d4, d1;
    logic [1:0]  rs;
    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset awready", a_awready, 1);
    check("reset wready", a_wready, 1);
    check("reset arready", a_arready, 1);
    check("reset bvalid", a_bvalid, 0);
    check("reset rvalid", a_rvalid, 0);
    check("reset bresp", a_bresp, RESP_OKAY);
    check("reset rresp", a_rresp, RESP_OKAY);
    check("reset timer_irq", a_tirq, 0);
    check("reset soft_irq", a_sirq, 0);

    // 40 idle cycles: 10 ticks at divide-by-4, 40 at divide-by-1
    repeat (40) @(negedge clk);
    axi_read(32'h0000_BFF8, d4, d1, rs);
    check("mtime div4 after 40", d4, 64'd10);
    check("mtime div1 after 40", d1, 64'd40);
    check("mtime rresp", rs, RESP_OKAY);

    axi_read(32'h0000_4000, d4, d1, rs);
    check("mtimecmp reset value", d4, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mtimecmp rresp", rs, RESP_OKAY);

    axi_write("cmp=5", 32'h0000_4000, 64'd5, 8'hFF, RESP_OKAY);
    check("timer_irq mtime above cmp", a_tirq, 1);
    axi_write("mtime=0", 32'h0000_BFF8, 64'd0, 8'hFF, RESP_OKAY);
    check("timer_irq after mtime cleared", a_tirq, 0);
    repeat (19) @(negedge clk);
    check("timer_irq as mtime reaches 5", a_tirq, 0);
    @(negedge clk);
    check("timer_irq cycle after mtime=5", a_tirq, 1);
    axi_write("cmp=max", 32'h0000_4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RESP_OKAY);
    check("timer_irq drops after cmp raised", a_tirq, 0);

    axi_write("zero strb", 32'h0000_4000, 64'd0, 8'h00, RESP_OKAY);
    axi_read(32'h0000_4000, d4, d1, rs);
    check("mtimecmp unchanged by zero strb", d4, 64'hFFFF_FFFF_FFFF_FFFF);

    // W leads AW by three cycles
    wvalid = 1'b1; wdata = 64'd1; wstrb = 8'h01;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    check("W_HAVE_W wready", a_wready, 0);
    check("W_HAVE_W awready", a_awready, 1);
    check("W_HAVE_W bvalid", a_bvalid, 0);
    repeat (2) @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    check("msip bvalid", a_bvalid, 1);
    check("msip bresp", a_bresp, RESP_OKAY);
    check("soft_irq not yet", a_sirq, 0);
    @(negedge clk);
    check("soft_irq raised", a_sirq, 1);
    repeat (4) @(negedge clk);
    check("bvalid held under backpressure", a_bvalid, 1);
    check("awready low while in W_RESP", a_awready, 0);
    check("wready low while in W_RESP", a_wready, 0);
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    check("bvalid after bready", a_bvalid, 0);
    check("awready after response", a_awready, 1);
    axi_read(32'h0000_0000, d4, d1, rs);
    check("msip readback", d4, 64'd1);

    axi_read(32'h0000_1000, d4, d1, rs);
    check("unmapped rresp", rs, RESP_DECERR);
    check("unmapped rdata", d4, 64'd0);
    axi_write("unmapped write", 32'h0000_1000, 64'd0, 8'hFF, RESP_DECERR);
    axi_read(32'h0000_0000, d4, d1, rs);
    check("msip after unmapped write", d4, 64'd1);
    axi_read(32'h0000_4000, d4, d1, rs);
    check("mtimecmp after unmapped write", d4, 64'hFFFF_FFFF_FFFF_FFFF);

    axi_write("mtime=max", 32'h0000_BFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RESP_OKAY);
    axi_read(32'h0000_BFF8, d4, d1, rs);
    check("mtime wraps to 0", d1, 64'd0);

    axi_write("mtime preset", 32'h0000_BFF8, 64'h0000_0005_FFFF_FFFE, 8'hFF, RESP_OKAY);
    axi_write("mtime low half", 32'h0000_BFF8, 64'h1111_1111_DEAD_BEEF, 8'h0F, RESP_OKAY);
    axi_read(32'h0000_BFF8, d4, d1, rs);
    check("partial write in tick cycle", d1, 64'h0000_0006_DEAD_BEF0);
    check("partial write off tick", d4, 64'h0000_0005_DEAD_BEEF);

    // Reset with a read response pending and the write FSM in W_HAVE_AW
    arvalid = 1'b1; araddr = 32'h0000_4000; awvalid = 1'b1; awaddr = 32'h0000_BFF8;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    check("pending rvalid", a_rvalid, 1);
    check("W_HAVE_AW awready", a_awready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid-reset rvalid", a_rvalid, 0);
    check("mid-reset bvalid", a_bvalid, 0);
    check("mid-reset awready", a_awready, 1);
    check("mid-reset wready", a_wready, 1);
    check("mid-reset arready", a_arready, 1);
    axi_read(32'h0000_BFF8, d4, d1, rs);
    check("mtime after mid reset div4", d4, 64'd0);
    check("mtime after mid reset div1", d1, 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
